histogram_lut_uygula: RTL and testbench



---
 rtl/histogram_lut_uygula_pkg.sv | 13 +
 rtl/histogram_lut_uygula_if.sv | 38 +++
 rtl/histogram_lut_uygula_lut_bellek.sv | 26 ++
 rtl/histogram_lut_uygula.sv | 124 ++++++++++++
 tb/tb_histogram_lut_uygula.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/histogram_lut_uygula_pkg.sv
// Shared constants and state encoding for the histogram LUT remapping stage.
package histogram_lut_uygula_pkg;

   localparam int PIXEL_BIT    = 8;
   localparam int LUT_DERINLIK = 1 << PIXEL_BIT;

   typedef enum logic [1:0] {
      BOS    = 2'd0,
      YUKLE  = 2'd1,
      UYGULA = 2'd2
   } durum_t;

endpackage

// File: rtl/histogram_lut_uygula_if.sv
// LUT-load and pixel-stream signals of histogram_lut_uygula, bundled with
// master (feeding side) and slave (the remapping block) modports.
interface histogram_lut_uygula_if
   import histogram_lut_uygula_pkg::*;
#(
   parameter int PIXEL_W = PIXEL_BIT
);

   logic               lut_basla_i;
   logic               lut_etkin_i;
   logic [PIXEL_W-1:0] lut_deger_i;
   logic               lut_tamam_o;
   logic               lut_gecerli_o;

   // Valid/ready: a pixel moves on a clock edge where its valid and the
   // receiver's ready are both high; an unaccepted valid keeps its data stable.
   logic               pixel_gecerli_i;
   logic [PIXEL_W-1:0] pixel_i;
   logic               pixel_hazir_o;
   logic               pixel_gecerli_o;
   logic [PIXEL_W-1:0] pixel_o;
   logic               pixel_hazir_i;

   modport master (
      output lut_basla_i, lut_etkin_i, lut_deger_i,
      output pixel_gecerli_i, pixel_i, pixel_hazir_i,
      input  lut_tamam_o, lut_gecerli_o,
      input  pixel_hazir_o, pixel_gecerli_o, pixel_o
   );

   modport slave (
      input  lut_basla_i, lut_etkin_i, lut_deger_i,
      input  pixel_gecerli_i, pixel_i, pixel_hazir_i,
      output lut_tamam_o, lut_gecerli_o,
      output pixel_hazir_o, pixel_gecerli_o, pixel_o
   );

endinterface

// File: rtl/histogram_lut_uygula_lut_bellek.sv
// 2^PIXEL_W x PIXEL_W register file: one synchronous write port, one
// combinational read port. Contents are deliberately not reset.
module histogram_lut_uygula_lut_bellek
   import histogram_lut_uygula_pkg::*;
#(
   parameter int PIXEL_W = PIXEL_BIT
) (
   input  logic               clk_i,
   input  logic               yaz_en,
   input  logic [PIXEL_W-1:0] yaz_adr,
   input  logic [PIXEL_W-1:0] yaz_veri,
   input  logic [PIXEL_W-1:0] oku_adr,
   output logic [PIXEL_W-1:0] oku_veri
);

   localparam int DERINLIK = 1 << PIXEL_W;

   logic [PIXEL_W-1:0] mem [DERINLIK];

   always_ff @(posedge clk_i) begin
      if (yaz_en) mem[yaz_adr] <= yaz_veri;
   end

   assign oku_veri = mem[oku_adr];

endmodule

// File: rtl/histogram_lut_uygula.sv
// Captures a 2^PIXEL_W-entry equalisation LUT and remaps a valid/ready pixel
// stream through it. Define HISTOGRAM_LUT_CIFT_TAMPON_EN for a shadow-bank reload.
module histogram_lut_uygula
   import histogram_lut_uygula_pkg::*;
#(
   parameter int PIXEL_W = PIXEL_BIT
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   histogram_lut_uygula_if.slave bus,
   output durum_t               durum_o
);

   localparam logic [PIXEL_W:0] SON_IDX = {1'b0, {PIXEL_W{1'b1}}};

   durum_t             durum_q, durum_d;
   logic [PIXEL_W:0]   yaz_idx_q, yaz_idx_d;
   logic [PIXEL_W-1:0] yaz_adr;
   logic               son_yazim;
   logic               yukle_bas;
   logic               tamam_q;
   logic               gecerli_q, gecerli_d;
   logic               cikis_gecerli_q;
   logic [PIXEL_W-1:0] cikis_pixel_q;
   logic [PIXEL_W-1:0] okunan;
   logic               hazir;
   logic               transfer;

   // A restart pulse redirects a same-cycle write to index 0.
   assign yaz_adr   = bus.lut_basla_i ? '0 : yaz_idx_q[PIXEL_W-1:0];
   assign son_yazim = bus.lut_etkin_i && !bus.lut_basla_i && (yaz_idx_q == SON_IDX);
   assign yukle_bas = bus.lut_basla_i || (bus.lut_etkin_i && (durum_q != YUKLE));

   assign hazir    = gecerli_q && (!cikis_gecerli_q || bus.pixel_hazir_i);
   assign transfer = bus.pixel_gecerli_i && hazir;

   always_comb begin
      durum_d   = durum_q;
      yaz_idx_d = yaz_idx_q;
      gecerli_d = gecerli_q;
      if (bus.lut_etkin_i) begin
         yaz_idx_d = son_yazim ? '0 : ({1'b0, yaz_adr} + {{PIXEL_W{1'b0}}, 1'b1});
      end else if (bus.lut_basla_i) begin
         yaz_idx_d = '0;
      end
      if (son_yazim) begin
         durum_d   = UYGULA;
         gecerli_d = 1'b1;
      end else if (yukle_bas) begin
         durum_d = YUKLE;
`ifndef HISTOGRAM_LUT_CIFT_TAMPON_EN
         gecerli_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum_q   <= BOS;
         yaz_idx_q <= '0;
         tamam_q   <= 1'b0;
         gecerli_q <= 1'b0;
      end else begin
         durum_q   <= durum_d;
         yaz_idx_q <= yaz_idx_d;
         tamam_q   <= son_yazim;
         gecerli_q <= gecerli_d;
      end
   end

   // Output register; it holds while downstream stalls, even during a reload.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cikis_gecerli_q <= 1'b0;
         cikis_pixel_q   <= '0;
      end else if (transfer) begin
         cikis_gecerli_q <= 1'b1;
         cikis_pixel_q   <= okunan;
      end else if (bus.pixel_hazir_i) begin
         cikis_gecerli_q <= 1'b0;
      end
   end

`ifdef HISTOGRAM_LUT_CIFT_TAMPON_EN
   logic               aktif_q;
   logic [PIXEL_W-1:0] oku [2];

   // Loads fill the bank that is not being read; completion swaps them.
   always_ff @(posedge clk_i) begin
      if (rst_i)          aktif_q <= 1'b0;
      else if (son_yazim) aktif_q <= !aktif_q;
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      histogram_lut_uygula_lut_bellek #(.PIXEL_W(PIXEL_W)) u_bellek (
         .clk_i    (clk_i),
         .yaz_en   (bus.lut_etkin_i && (aktif_q != 1'(b))),
         .yaz_adr  (yaz_adr),
         .yaz_veri (bus.lut_deger_i),
         .oku_adr  (bus.pixel_i),
         .oku_veri (oku[b])
      );
   end

   assign okunan = oku[aktif_q];
`else
   histogram_lut_uygula_lut_bellek #(.PIXEL_W(PIXEL_W)) u_bellek (
      .clk_i    (clk_i),
      .yaz_en   (bus.lut_etkin_i),
      .yaz_adr  (yaz_adr),
      .yaz_veri (bus.lut_deger_i),
      .oku_adr  (bus.pixel_i),
      .oku_veri (okunan)
   );
`endif

   assign bus.lut_tamam_o     = tamam_q;
   assign bus.lut_gecerli_o   = gecerli_q;
   assign bus.pixel_hazir_o   = hazir;
   assign bus.pixel_gecerli_o = cikis_gecerli_q;
   assign bus.pixel_o         = cikis_pixel_q;
   assign durum_o             = durum_q;

endmodule

// File: tb/tb_histogram_lut_uygula.sv
// Bench for histogram_lut_uygula: table vectors, hand-written reload/reset
// sequences and a negedge scoreboard fed by a bench-side LUT model.
module tb_histogram_lut_uygula;
   import histogram_lut_uygula_pkg::*;

   typedef struct {
      logic [7:0] pix;
      logic [7:0] exp;
   } vec_t;

   logic   clk = 1'b0;
   logic   rst;
   durum_t durum;

   histogram_lut_uygula_if bus ();

   histogram_lut_uygula dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .bus     (bus),
      .durum_o (durum)
   );

   always #5 clk = ~clk;

   int         checks    = 0;
   int         failures  = 0;
   int         tamam_cnt = 0;
   int         stall_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] model_lut [LUT_DERINLIK];
   logic [7:0] pend_lut  [LUT_DERINLIK];
   bit         prev_stall = 1'b0;
   logic [7:0] prev_pix;
   logic [7:0] sb_e;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Scoreboard: model swap on completion, then pop, then push.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (bus.lut_tamam_o) begin
            tamam_cnt++;
            for (int i = 0; i < LUT_DERINLIK; i++) model_lut[i] = pend_lut[i];
         end
         if (prev_stall) begin
            chk("hold_valid", bus.pixel_gecerli_o, 1);
            chk("hold_data", bus.pixel_o, prev_pix);
         end
         if (bus.pixel_gecerli_o && bus.pixel_hazir_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected actual=%0d expected=none", bus.pixel_o);
            end else begin
               sb_e = exp_q.pop_front();
               chk("sb_pixel", bus.pixel_o, sb_e);
            end
         end
         if (bus.pixel_gecerli_i && bus.pixel_hazir_o) exp_q.push_back(model_lut[bus.pixel_i]);
         prev_stall = bus.pixel_gecerli_o && !bus.pixel_hazir_i;
         prev_pix   = bus.pixel_o;
      end
   end

   // tur 0: LUT[i]=255-i, tur 1: identity.
   task automatic lut_yukle(input int tur, input int n, input bit basla);
      for (int i = 0; i < LUT_DERINLIK; i++) pend_lut[i] = (tur == 0) ? 8'(255 - i) : 8'(i);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.lut_basla_i = basla && (i == 0);
         bus.lut_etkin_i = 1'b1;
         bus.lut_deger_i = pend_lut[i];
      end
      @(posedge clk); #1;
      bus.lut_basla_i = 1'b0;
      bus.lut_etkin_i = 1'b0;
   endtask

   task automatic tek_pixel(input string nm, input logic [7:0] p, input logic [7:0] e);
      bit acc = 1'b0;
      @(posedge clk); #1;
      bus.pixel_gecerli_i = 1'b1;
      bus.pixel_i         = p;
      bus.pixel_hazir_i   = 1'b1;
      for (int k = 0; k < 20 && !acc; k++) begin
         @(negedge clk);
         acc = bus.pixel_hazir_o;
         @(posedge clk); #1;
      end
      bus.pixel_gecerli_i = 1'b0;
      chk({nm, "_accept"}, acc, 1);
      chk({nm, "_valid"}, bus.pixel_gecerli_o, 1);
      chk({nm, "_data"}, bus.pixel_o, e);
   endtask

   task automatic akis(input int n, input bit toggle);
      int idx    = 0;
      int budget = 0;
      bit acc;
      @(posedge clk); #1;
      bus.pixel_gecerli_i = 1'b1;
      bus.pixel_i         = 8'($urandom_range(0, 255));
      bus.pixel_hazir_i   = 1'b1;
      while (idx < n && budget < n * 4 + 20) begin
         @(negedge clk);
         acc = bus.pixel_hazir_o;
         if (!acc) stall_cnt++;
         @(posedge clk); #1;
         budget++;
         if (acc) begin
            idx++;
            bus.pixel_i = 8'($urandom_range(0, 255));
         end
         if (toggle) bus.pixel_hazir_i = !bus.pixel_hazir_i;
      end
      bus.pixel_gecerli_i = 1'b0;
      bus.pixel_hazir_i   = 1'b1;
      chk("stream_count", idx, n);
   endtask

   task automatic cikis_sifir(input string pfx);
      chk({pfx, "_tamam"}, bus.lut_tamam_o, 0);
      chk({pfx, "_lut_valid"}, bus.lut_gecerli_o, 0);
      chk({pfx, "_ready"}, bus.pixel_hazir_o, 0);
      chk({pfx, "_out_valid"}, bus.pixel_gecerli_o, 0);
      chk({pfx, "_out_data"}, bus.pixel_o, 0);
      chk({pfx, "_state"}, int'(durum), int'(BOS));
   endtask

   initial begin
      vec_t tbl1 [3];
      vec_t tbl2 [3];
      int   t0;
      tbl1[0] = '{pix: 8'd0,   exp: 8'd255};
      tbl1[1] = '{pix: 8'd10,  exp: 8'd245};
      tbl1[2] = '{pix: 8'd255, exp: 8'd0};
      tbl2[0] = '{pix: 8'd50,  exp: 8'd50};
      tbl2[1] = '{pix: 8'd0,   exp: 8'd0};
      tbl2[2] = '{pix: 8'd200, exp: 8'd200};

      bus.lut_basla_i     = 1'b0;
      bus.lut_etkin_i     = 1'b0;
      bus.lut_deger_i     = '0;
      bus.pixel_gecerli_i = 1'b0;
      bus.pixel_i         = '0;
      bus.pixel_hazir_i   = 1'b1;
      rst                 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      cikis_sifir("reset");

      // Full 255-i load straight out of reset.
      t0 = tamam_cnt;
      lut_yukle(0, 256, 1'b0);
      chk("load1_tamam", bus.lut_tamam_o, 1);
      chk("load1_lut_valid", bus.lut_gecerli_o, 1);
      chk("load1_ready", bus.pixel_hazir_o, 1);
      chk("load1_state", int'(durum), int'(UYGULA));
      @(posedge clk); #1;
      chk("load1_tamam_pulse", bus.lut_tamam_o, 0);
      chk("load1_tamam_count", tamam_cnt - t0, 1);
      for (int i = 0; i < 3; i++) tek_pixel("inv", tbl1[i].pix, tbl1[i].exp);

      // Interrupted load, then restart with identity.
      t0 = tamam_cnt;
      lut_yukle(0, 100, 1'b0);
      lut_yukle(1, 256, 1'b1);
      repeat (2) @(posedge clk);
      #1 chk("restart_tamam_count", tamam_cnt - t0, 1);
      for (int i = 0; i < 3; i++) tek_pixel("ident", tbl2[i].pix, tbl2[i].exp);

      // Stream with downstream ready toggling every cycle.
      akis(20, 1'b1);
      repeat (4) @(posedge clk);
      #1 chk("stream_queue_empty", exp_q.size(), 0);

`ifndef HISTOGRAM_LUT_CIFT_TAMPON_EN
      // Reload mid-stream while an output is stalled in the register.
      @(posedge clk); #1;
      bus.pixel_gecerli_i = 1'b1;
      bus.pixel_i         = 8'd40;
      bus.pixel_hazir_i   = 1'b1;
      @(posedge clk); #1;
      bus.pixel_hazir_i = 1'b0;
      bus.pixel_i       = 8'd90;
      fork
         lut_yukle(0, 256, 1'b1);
         begin
            repeat (2) @(posedge clk);
            #2;
            chk("reload_ready", bus.pixel_hazir_o, 0);
            chk("reload_lut_valid", bus.lut_gecerli_o, 0);
            chk("reload_pending", bus.pixel_gecerli_o, 1);
            chk("reload_state", int'(durum), int'(YUKLE));
            bus.pixel_hazir_i = 1'b1;
         end
      join
      chk("reload_resume_ready", bus.pixel_hazir_o, 1);
      @(posedge clk); #1;
      bus.pixel_gecerli_i = 1'b0;
      chk("reload_new_valid", bus.pixel_gecerli_o, 1);
      chk("reload_new_data", bus.pixel_o, 165);
`else
      // Continuous stream across a shadow-bank reload: no stalls allowed.
      lut_yukle(0, 256, 1'b1);
      tek_pixel("dbl_inv", 8'd10, 8'd245);
      stall_cnt = 0;
      fork
         akis(300, 1'b0);
         begin
            repeat (20) @(posedge clk);
            lut_yukle(1, 256, 1'b1);
         end
      join
      chk("dbl_stalls", stall_cnt, 0);
      tek_pixel("dbl_ident", 8'd10, 8'd10);
`endif

      // Reset in the middle of a load.
      lut_yukle(1, 50, 1'b1);
      rst                 = 1'b1;
      bus.pixel_gecerli_i = 1'b1;
      bus.pixel_i         = 8'd3;
      @(posedge clk); #1;
      rst = 1'b0;
      cikis_sifir("rst_load");
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("rst_load_ready_low", bus.pixel_hazir_o, 0);
      end
      bus.pixel_gecerli_i = 1'b0;

      // Reset while an output is stalled.
      lut_yukle(0, 256, 1'b0);
      chk("rst_stall_tamam", bus.lut_tamam_o, 1);
      @(posedge clk); #1;
      bus.pixel_gecerli_i = 1'b1;
      bus.pixel_i         = 8'd7;
      bus.pixel_hazir_i   = 1'b0;
      @(posedge clk); #1;
      bus.pixel_gecerli_i = 1'b0;
      chk("rst_stall_pending", bus.pixel_gecerli_o, 1);
      chk("rst_stall_data", bus.pixel_o, 248);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      cikis_sifir("rst_stall");
      bus.pixel_hazir_i   = 1'b1;
      bus.pixel_gecerli_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("rst_stall_ready_low", bus.pixel_hazir_o, 0);
      end
      bus.pixel_gecerli_i = 1'b0;

      lut_yukle(1, 256, 1'b0);
      tek_pixel("recover", 8'd200, 8'd200);
      repeat (3) @(posedge clk);
      #1 chk("final_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
